// File: rtl/axi_ad9364_tx_sched.sv
// axi_ad9364_tx_sched: two-source round-robin Tx sample scheduler feeding a small FIFO, with DAC strobe pacing.
// Build macro AD9364_TX_SCHED_HOLD_EN: underflow strobes repeat the last popped sample instead of driving zeros.
//
// state | meaning
// IDLE  | FIFO flushed, no source accepted, no strobes
// FILL  | accepting samples until fifo_level reaches PREFILL
// RUN   | accepting samples, dac_valid strobe every 2 (1R1T) or 4 (2R2T) clk
module axi_ad9364_tx_sched #(
    parameter int FIFO_AW = 2,
    parameter int PREFILL = 2,
    parameter int UCNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 r1_mode,
    input  logic                 src0_valid,
    input  logic [47:0]          src0_data,
    output logic                 src0_ready,
    input  logic                 src1_valid,
    input  logic [47:0]          src1_data,
    output logic                 src1_ready,
    output logic                 dac_valid,
    output logic [11:0]          dac_data_i1,
    output logic [11:0]          dac_data_q1,
    output logic [11:0]          dac_data_i2,
    output logic [11:0]          dac_data_q2,
    output logic                 dac_r1_mode,
    output logic [FIFO_AW:0]     fifo_level,
    output logic [UCNT_W-1:0]    underflow_cnt,
    output logic [1:0]           state
);

    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_FILL = 2'b01;
    localparam logic [1:0] ST_RUN  = 2'b10;

    localparam logic [FIFO_AW:0]   LVL_FULL    = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   LVL_PREFILL = (FIFO_AW + 1)'(PREFILL);
    localparam logic [FIFO_AW:0]   LVL_ONE     = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE     = (FIFO_AW)'(1);
    localparam logic [UCNT_W-1:0]  UCNT_ONE    = (UCNT_W)'(1);

    logic [47:0]        fifo_mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic               rr_ptr;
    logic [1:0]         pace_cnt;
    logic [1:0]         pace_max;

    logic               active;
    logic               full;
    logic               grant0;
    logic               grant1;
    logic               push;
    logic               strobe;
    logic               pop;
    logic [47:0]        push_data;
    logic [47:0]        uf_smp;
    logic [47:0]        out_smp;

`ifdef AD9364_TX_SCHED_HOLD_EN
    logic [47:0]        last_smp;
`endif

    // Arbitration looks only at registered state: a pop in the same clk never frees a slot for a push.
    always_comb begin
        active     = (state == ST_FILL) || (state == ST_RUN);
        full       = (fifo_level == LVL_FULL);
        grant0     = src0_valid & (~src1_valid | ~rr_ptr);
        grant1     = src1_valid & (~src0_valid | rr_ptr);
        src0_ready = active & ~full & grant0;
        src1_ready = active & ~full & grant1;
        push       = src0_ready | src1_ready;
        push_data  = src1_ready ? src1_data : src0_data;
    end

    always_comb begin
        pace_max = dac_r1_mode ? 2'd1 : 2'd3;
        strobe   = (state == ST_RUN) && (pace_cnt == 2'd0);
        pop      = strobe && (fifo_level != '0);
`ifdef AD9364_TX_SCHED_HOLD_EN
        uf_smp   = last_smp;
`else
        uf_smp   = '0;
`endif
        out_smp  = pop ? fifo_mem[rd_ptr] : uf_smp;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_level    <= '0;
            rr_ptr        <= 1'b0;
            pace_cnt      <= 2'd0;
            dac_valid     <= 1'b0;
            dac_data_i1   <= '0;
            dac_data_q1   <= '0;
            dac_data_i2   <= '0;
            dac_data_q2   <= '0;
            dac_r1_mode   <= 1'b1;
            underflow_cnt <= '0;
        end else if (!enable) begin
            // Flush: output data and the underflow count are deliberately left untouched.
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            pace_cnt   <= 2'd0;
            dac_valid  <= 1'b0;
        end else begin
            dac_valid <= strobe;
            if (strobe) begin
                {dac_data_q2, dac_data_i2, dac_data_q1, dac_data_i1} <= out_smp;
                if (!pop && (underflow_cnt != '1)) begin
                    underflow_cnt <= underflow_cnt + UCNT_ONE;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                rr_ptr <= ~rr_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_ONE;
                2'b01:   fifo_level <= fifo_level - LVL_ONE;
                default: fifo_level <= fifo_level;
            endcase
            case (state)
                ST_IDLE: begin
                    state       <= ST_FILL;
                    dac_r1_mode <= r1_mode;
                end
                ST_FILL: begin
                    pace_cnt <= 2'd0;
                    if (fifo_level >= LVL_PREFILL) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    pace_cnt <= (pace_cnt == pace_max) ? 2'd0 : pace_cnt + 2'd1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef AD9364_TX_SCHED_HOLD_EN
    // Held sample is forgotten on flush so the first underflow after IDLE drives zeros.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            last_smp <= '0;
        end else if (pop) begin
            last_smp <= fifo_mem[rd_ptr];
        end
    end
`endif

endmodule

// File: tb/tb_axi_ad9364_tx_sched.sv
// Randomized bench for axi_ad9364_tx_sched against a queue-based scheduling model.
// A second instance with a 4-bit underflow counter exercises counter saturation.
module tb_axi_ad9364_tx_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        r1_mode = 1'b1;
    logic        src0_valid = 1'b0;
    logic        src1_valid = 1'b0;
    logic [47:0] src0_data = '0;
    logic [47:0] src1_data = '0;

    logic        src0_ready, src1_ready, dac_valid, dac_r1_mode;
    logic [11:0] dac_data_i1, dac_data_q1, dac_data_i2, dac_data_q2;
    logic [2:0]  fifo_level;
    logic [15:0] underflow_cnt;
    logic [1:0]  state;

    logic        w4_src0_ready, w4_src1_ready, w4_dac_valid, w4_dac_r1_mode;
    logic [11:0] w4_i1, w4_q1, w4_i2, w4_q2;
    logic [2:0]  w4_fifo_level;
    logic [3:0]  w4_underflow_cnt;
    logic [1:0]  w4_state;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    axi_ad9364_tx_sched #(.FIFO_AW(2), .PREFILL(2), .UCNT_W(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .r1_mode(r1_mode),
        .src0_valid(src0_valid), .src0_data(src0_data), .src0_ready(src0_ready),
        .src1_valid(src1_valid), .src1_data(src1_data), .src1_ready(src1_ready),
        .dac_valid(dac_valid), .dac_data_i1(dac_data_i1), .dac_data_q1(dac_data_q1),
        .dac_data_i2(dac_data_i2), .dac_data_q2(dac_data_q2), .dac_r1_mode(dac_r1_mode),
        .fifo_level(fifo_level), .underflow_cnt(underflow_cnt), .state(state)
    );

    axi_ad9364_tx_sched #(.FIFO_AW(2), .PREFILL(2), .UCNT_W(4)) dut_w4 (
        .clk(clk), .rst(rst), .enable(enable), .r1_mode(r1_mode),
        .src0_valid(src0_valid), .src0_data(src0_data), .src0_ready(w4_src0_ready),
        .src1_valid(src1_valid), .src1_data(src1_data), .src1_ready(w4_src1_ready),
        .dac_valid(w4_dac_valid), .dac_data_i1(w4_i1), .dac_data_q1(w4_q1),
        .dac_data_i2(w4_i2), .dac_data_q2(w4_q2), .dac_r1_mode(w4_dac_r1_mode),
        .fifo_level(w4_fifo_level), .underflow_cnt(w4_underflow_cnt), .state(w4_state)
    );

    // Reference model: a sample queue, a count of clocks spent in RUN, and the strobe rule
    // "strobe whenever clocks-in-RUN is a multiple of the period".
    logic [1:0]  m_st = 2'b00;
    int          m_lvl = 0;
    logic [47:0] m_q[$];
    logic        m_rr = 1'b0;
    logic        m_mode = 1'b1;
    logic        m_valid = 1'b0;
    logic [47:0] m_data = '0;
    logic [47:0] m_last = '0;
    int          m_ucnt = 0;
    int          m_ucnt4 = 0;
    int          m_runcyc = 0;
    logic        m_rdy0, m_rdy1;

    assign m_rdy0 = (m_st != 2'b00) && (m_lvl < 4) && src0_valid && (!src1_valid || !m_rr);
    assign m_rdy1 = (m_st != 2'b00) && (m_lvl < 4) && src1_valid && (!src0_valid || m_rr);

    always @(posedge clk) begin
        bit p0, p1;
        int per, lvl_before;
        p0 = m_rdy0;
        p1 = m_rdy1;
        lvl_before = m_lvl;
        if (rst) begin
            m_st = 2'b00; m_q.delete(); m_lvl = 0; m_rr = 1'b0; m_mode = 1'b1;
            m_runcyc = 0; m_valid = 1'b0; m_data = '0; m_last = '0; m_ucnt = 0; m_ucnt4 = 0;
        end else if (!enable) begin
            m_st = 2'b00; m_q.delete(); m_lvl = 0; m_runcyc = 0; m_valid = 1'b0; m_last = '0;
        end else begin
            per = m_mode ? 2 : 4;
            m_valid = 1'b0;
            if (m_st == 2'b10 && (m_runcyc % per) == 0) begin
                m_valid = 1'b1;
                if (m_q.size() > 0) begin
                    m_data = m_q.pop_front();
                    m_last = m_data;
                end else begin
`ifdef AD9364_TX_SCHED_HOLD_EN
                    m_data = m_last;
`else
                    m_data = '0;
`endif
                    m_ucnt  = (m_ucnt < 65535) ? m_ucnt + 1 : 65535;
                    m_ucnt4 = (m_ucnt4 < 15) ? m_ucnt4 + 1 : 15;
                end
            end
            if (p0) m_q.push_back(src0_data);
            else if (p1) m_q.push_back(src1_data);
            if (p0 || p1) m_rr = !m_rr;
            m_lvl = m_q.size();
            case (m_st)
                2'b00: begin m_st = 2'b01; m_mode = r1_mode; end
                2'b01: if (lvl_before >= 2) begin m_st = 2'b10; m_runcyc = 0; end
                default: m_runcyc++;
            endcase
        end
    end

    logic [76:0] obs, expv;
    assign obs  = {state, fifo_level, dac_valid, dac_r1_mode, src0_ready, src1_ready,
                   underflow_cnt, w4_underflow_cnt, dac_data_q2, dac_data_i2, dac_data_q1, dac_data_i1};
    assign expv = {m_st, 3'(m_lvl), m_valid, m_mode, m_rdy0, m_rdy1,
                   16'(m_ucnt), 4'(m_ucnt4), m_data};

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; src0_valid = 1'b0; src1_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if (obs !== expv) $display("FAIL reset_model obs=%h exp=%h", obs, expv);
        else n_pass++;
        n_total++;
        if ({state, fifo_level, dac_valid, underflow_cnt, dac_data_i1, dac_r1_mode} !== {2'b00, 3'd0, 1'b0, 16'd0, 12'd0, 1'b1})
            $display("FAIL reset_values state=%b lvl=%0d r1=%b", state, fifo_level, dac_r1_mode);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_fill_r1();
        int strobes = 0;
        enable = 1'b1; r1_mode = 1'b1;
        src0_valid = 1'b1; src0_data = 48'h0000_0000_07FF; src1_valid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            n_total++;
            if (obs !== expv) $display("FAIL fill_r1 t=%0t obs=%h exp=%h", $time, obs, expv);
            else n_pass++;
            if (dac_valid) begin
                strobes++;
                n_total++;
                if (dac_data_i1 !== 12'h7FF) $display("FAIL fill_r1_i1 got=%h want=7ff", dac_data_i1);
                else n_pass++;
            end
        end
        n_total++;
        if (strobes < 15 || underflow_cnt !== 16'd0)
            $display("FAIL fill_r1_rate strobes=%0d ucnt=%0d want>=15,0", strobes, underflow_cnt);
        else n_pass++;
    endtask

    task automatic test_both_sources();
        src0_valid = 1'b1; src1_valid = 1'b1;
        repeat (60) begin
            src0_data = {$urandom, $urandom};
            src1_data = {$urandom, $urandom};
            @(negedge clk);
            n_total++;
            if (obs !== expv) $display("FAIL both_src t=%0t obs=%h exp=%h", $time, obs, expv);
            else n_pass++;
            n_total++;
            if (fifo_level == 3'd4 && (src0_ready || src1_ready))
                $display("FAIL both_src_full_ready r0=%b r1=%b want 0,0", src0_ready, src1_ready);
            else n_pass++;
        end
    endtask

    task automatic test_r2_mode();
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1; r1_mode = 1'b0;
        for (int i = 0; i < 80; i++) begin
            src0_data = {$urandom, $urandom};
            src1_data = {$urandom, $urandom};
            src0_valid = ($urandom_range(0, 3) != 0);
            src1_valid = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (i > 10) r1_mode = $urandom_range(0, 1);
            n_total++;
            if (obs !== expv) $display("FAIL r2_mode t=%0t obs=%h exp=%h", $time, obs, expv);
            else n_pass++;
        end
        n_total++;
        if (dac_r1_mode !== 1'b0) $display("FAIL r2_latched got=%b want=0", dac_r1_mode);
        else n_pass++;
    endtask

    task automatic test_underflow();
        int guard = 0;
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1; r1_mode = 1'b1; src0_valid = 1'b1; src1_valid = 1'b0;
        src0_data = {$urandom, $urandom};
        while (m_st != 2'b10 && guard < 20) begin
            @(negedge clk);
            guard++;
            n_total++;
            if (obs !== expv) $display("FAIL uf_fill t=%0t obs=%h exp=%h", $time, obs, expv);
            else n_pass++;
        end
        n_total++;
        if (state !== 2'b10) $display("FAIL uf_reach_run state=%b want=10", state);
        else n_pass++;
        src0_valid = 1'b0;
        repeat (30) begin
            @(negedge clk);
            n_total++;
            if (obs !== expv) $display("FAIL underflow t=%0t obs=%h exp=%h", $time, obs, expv);
            else n_pass++;
        end
    endtask

    task automatic test_disable();
        int guard = 0;
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1; r1_mode = 1'b0; src0_valid = 1'b1; src1_valid = 1'b1;
        while (m_lvl != 3 && guard < 40) begin
            src0_data = {$urandom, $urandom};
            src1_data = {$urandom, $urandom};
            @(negedge clk);
            guard++;
            n_total++;
            if (obs !== expv) $display("FAIL dis_fill t=%0t obs=%h exp=%h", $time, obs, expv);
            else n_pass++;
        end
        n_total++;
        if (fifo_level !== 3'd3) $display("FAIL dis_level3 got=%0d want=3", fifo_level);
        else n_pass++;
        enable = 1'b0; src0_valid = 1'b0; src1_valid = 1'b0;
        @(negedge clk);
        n_total++;
        if ({state, fifo_level, dac_valid} !== 6'd0)
            $display("FAIL dis_flush state=%b lvl=%0d valid=%b want 0", state, fifo_level, dac_valid);
        else n_pass++;
        src0_valid = 1'b1; src1_valid = 1'b1;
        @(negedge clk);
        n_total++;
        if ({src0_ready, src1_ready} !== 2'b00) $display("FAIL dis_ready got=%b%b want=00", src0_ready, src1_ready);
        else n_pass++;
        enable = 1'b1;
        repeat (12) begin
            src0_data = {$urandom, $urandom};
            src1_data = {$urandom, $urandom};
            @(negedge clk);
            n_total++;
            if (obs !== expv) $display("FAIL dis_reenable t=%0t obs=%h exp=%h", $time, obs, expv);
            else n_pass++;
        end
    endtask

    task automatic test_saturate();
        int guard = 0;
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1; r1_mode = 1'b1; src0_valid = 1'b1; src1_valid = 1'b0;
        while (m_st != 2'b10 && guard < 20) begin
            src0_data = {$urandom, $urandom};
            @(negedge clk);
            guard++;
        end
        src0_valid = 1'b0;
        repeat (50) begin
            @(negedge clk);
            n_total++;
            if (obs !== expv) $display("FAIL saturate t=%0t obs=%h exp=%h", $time, obs, expv);
            else n_pass++;
        end
        n_total++;
        if (w4_underflow_cnt !== 4'hF || underflow_cnt <= 16'd15)
            $display("FAIL sat_value w4=%h w16=%0d want F,>15", w4_underflow_cnt, underflow_cnt);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_total++;
        if ({state, fifo_level, dac_valid, underflow_cnt, w4_underflow_cnt, dac_data_q2, dac_data_i2,
             dac_data_q1, dac_data_i1} !== '0 || dac_r1_mode !== 1'b1)
            $display("FAIL mid_run_rst state=%b lvl=%0d ucnt=%0d r1=%b", state, fifo_level, underflow_cnt, dac_r1_mode);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_random();
        int dens0 = 2, dens1 = 2;
        for (int i = 0; i < 3000; i++) begin
            if ((i % 200) == 0) begin
                dens0 = $urandom_range(0, 4);
                dens1 = $urandom_range(0, 4);
            end
            rst        = ($urandom_range(0, 299) == 0);
            enable     = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 15) == 0) r1_mode = ~r1_mode;
            src0_valid = ($urandom_range(0, 3) < dens0);
            src1_valid = ($urandom_range(0, 3) < dens1);
            src0_data  = {$urandom, $urandom};
            src1_data  = {$urandom, $urandom};
            @(negedge clk);
            n_total++;
            if (obs !== expv) $display("FAIL random t=%0t obs=%h exp=%h", $time, obs, expv);
            else n_pass++;
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill_r1();
        test_both_sources();
        test_r2_mode();
        test_underflow();
        test_disable();
        test_saturate();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
